// File: rtl/nibble_unloader_if.sv
// Pattern-in / nibble-out bundle between the pattern register and the display path.
// master drives the pattern side; slave is the unloader itself.
interface nibble_unloader_if #(
  parameter int NIBBLES = 4,
  parameter int NW      = 4,
  parameter int IW      = 2
);
  localparam int PW = NIBBLES * NW;

  logic          load;
  logic [PW-1:0] in_pattern;
  logic          push_button;
  logic          logout;
  logic [NW-1:0] out_nibble;
  logic          nibble_valid;
  logic [IW-1:0] nibble_index;
  logic          busy;
  logic          done;

  modport master (
    output load, in_pattern, push_button, logout,
    input  out_nibble, nibble_valid, nibble_index, busy, done
  );

  modport slave (
    input  load, in_pattern, push_button, logout,
    output out_nibble, nibble_valid, nibble_index, busy, done
  );
endinterface

// File: rtl/nibble_unloader.sv
// Replays a latched pattern one nibble at a time, MSB nibble first, stepped by
// rising edges of push_button; flags done and waits for logout. 2**IW >= NIBBLES.
module nibble_unloader #(
  parameter int NIBBLES = 4,
  parameter int NW      = 4,
  parameter int IW      = 2
) (
  input logic               clk,
  input logic               reset,
  nibble_unloader_if.slave  bus
);
  localparam int            PW       = NIBBLES * NW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] pattern, pattern_d;
  logic [IW-1:0] index, index_d;
  logic          btn_prev;
  logic          step;

  logic [NW-1:0] out_nibble_q, out_nibble_d;
  logic          nibble_valid_q, nibble_valid_d;
  logic [IW-1:0] nibble_index_q, nibble_index_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign step = bus.push_button & ~btn_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pattern        <= '0;
      index          <= '0;
      btn_prev       <= 1'b0;
      out_nibble_q   <= '0;
      nibble_valid_q <= 1'b0;
      nibble_index_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state          <= state_d;
      pattern        <= pattern_d;
      index          <= index_d;
      btn_prev       <= bus.push_button;
      out_nibble_q   <= out_nibble_d;
      nibble_valid_q <= nibble_valid_d;
      nibble_index_q <= nibble_index_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    pattern_d = pattern;
    index_d   = index;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          state_d   = SHOW;
          pattern_d = bus.in_pattern;
          index_d   = '0;
        end
      end
      SHOW: begin
        // logout wins over a simultaneous step
        if (bus.logout) begin
          state_d = IDLE;
          index_d = '0;
        end else if (step) begin
          if (index == LAST_IDX) begin
            state_d = DONE;
            index_d = '0;
          end else begin
            index_d = index + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.logout) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the new nibble
  // appears one cycle after the load or step that selects it.
  always_comb begin
    out_nibble_d   = '0;
    nibble_valid_d = 1'b0;
    nibble_index_d = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    unique case (state_d)
      SHOW: begin
        nibble_valid_d = 1'b1;
        nibble_index_d = index_d;
        busy_d         = 1'b1;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (index_d == IW'(i)) begin
            out_nibble_d = pattern_d[PW-1-NW*i -: NW];
          end
        end
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.out_nibble   = out_nibble_q;
  assign bus.nibble_valid = nibble_valid_q;
  assign bus.nibble_index = nibble_index_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_nibble_unloader.sv
// Bench for nibble_unloader: directed scenarios plus random traffic, all checked
// against a queue-of-remaining-nibbles reference model.
module tb_nibble_unloader;
  localparam int NIBBLES = 4;
  localparam int NW      = 4;
  localparam int IW      = 2;
  localparam int PW      = NIBBLES * NW;
  localparam int VW      = NW + IW + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibble_unloader_if #(.NIBBLES(NIBBLES), .NW(NW), .IW(IW)) bus ();

  nibble_unloader #(.NIBBLES(NIBBLES), .NW(NW), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: active replay holds the nibbles not yet stepped past; empty queue while active = done.
  bit            m_active;
  bit            m_prev;
  logic [NW-1:0] m_q[$];

  function automatic logic [VW-1:0] exp_vec();
    if (!m_active) return '0;
    if (m_q.size() == 0) return {{NW{1'b0}}, 1'b0, {IW{1'b0}}, 1'b1, 1'b1};
    return {m_q[0], 1'b1, IW'(NIBBLES - m_q.size()), 1'b1, 1'b0};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.out_nibble, bus.nibble_valid, bus.nibble_index, bus.busy, bus.done};
  endfunction

  task automatic tick(input bit rst, input bit ld, input logic [PW-1:0] pat,
                      input bit btn, input bit lo);
    bit stp;
    reset           = rst;
    bus.load        = ld;
    bus.in_pattern  = pat;
    bus.push_button = btn;
    bus.logout      = lo;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
      m_q.delete();
    end else begin
      stp    = btn && !m_prev;
      m_prev = btn;
      if (!m_active) begin
        if (ld) begin
          m_active = 1'b1;
          m_q.delete();
          for (int i = NIBBLES - 1; i >= 0; i--) m_q.push_back(pat[i*NW +: NW]);
        end
      end else if (lo) begin
        m_active = 1'b0;
        m_q.delete();
      end else if (stp && m_q.size() > 0) begin
        void'(m_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, '0, 0, 0);
    tick(1, 0, '0, 0, 0);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_init got=%h exp=%h", dut_vec(), '0);
    end
    tick(0, 1, 16'hA5C3, 0, 0);
    tick(0, 0, '0, 1, 0); tick(0, 0, '0, 0, 0);
    tick(0, 0, '0, 1, 0); tick(0, 0, '0, 0, 0);
    total++;
    if (bus.out_nibble !== 4'hC || bus.nibble_index !== 2'd2 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL reset_pre got=%h/%0d exp=c/2", bus.out_nibble, bus.nibble_index);
    end
    tick(1, 0, '0, 0, 0);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_mid got=%h exp=%h", dut_vec(), '0);
    end
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0, 1, 0);
      tick(0, 0, '0, 0, 0);
      total++;
      if (dut_vec() !== '0 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle_press%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    logic [NW-1:0] exp_n [NIBBLES] = '{4'hA, 4'h5, 4'hC, 4'h3};
    tick(0, 1, 16'hA5C3, 0, 0);
    total++;
    if (dut_vec() !== {4'hA, 1'b1, 2'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL basic_first got=%h exp=%h", dut_vec(), {4'hA, 1'b1, 2'd0, 1'b1, 1'b0});
    end
    for (int i = 1; i < NIBBLES; i++) begin
      tick(0, 0, '0, 1, 0);
      total++;
      if (bus.out_nibble !== exp_n[i] || bus.nibble_index !== IW'(i) || bus.nibble_valid !== 1'b1) begin
        bad++; $display("FAIL basic_step%0d got=%h/%0d exp=%h/%0d",
                        i, bus.out_nibble, bus.nibble_index, exp_n[i], i);
      end
      tick(0, 0, '0, 0, 0);
    end
    tick(0, 0, '0, 1, 0);
    total++;
    if (dut_vec() !== {4'h0, 1'b0, 2'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL basic_done got=%h exp=%h", dut_vec(), {4'h0, 1'b0, 2'd0, 1'b1, 1'b1});
    end
    tick(0, 0, '0, 0, 1);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL basic_logout got=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_held_button();
    tick(0, 1, 16'h1234, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, '0, 1, 0);
    total++;
    if (bus.out_nibble !== 4'h1 || bus.nibble_index !== 2'd0) begin
      bad++; $display("FAIL held_at_load got=%h/%0d exp=1/0", bus.out_nibble, bus.nibble_index);
    end
    tick(0, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, '0, 1, 0);
      total++;
      if (bus.out_nibble !== 4'h2 || bus.nibble_index !== 2'd1 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL held_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    tick(0, 0, '0, 0, 1);
  endtask

  task automatic test_priority();
    logic [PW-1:0] pat = PW'($urandom);
    tick(0, 1, pat, 0, 0);
    tick(0, 0, '0, 1, 0);
    tick(0, 0, '0, 0, 0);
    total++;
    if (bus.nibble_index !== 2'd1 || bus.out_nibble !== pat[11:8]) begin
      bad++; $display("FAIL prio_setup got=%h/%0d exp=%h/1", bus.out_nibble, bus.nibble_index, pat[11:8]);
    end
    tick(0, 0, '0, 1, 1);
    total++;
    if (dut_vec() !== '0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL prio_logout got=%h exp=0", dut_vec());
    end
    tick(0, 0, '0, 0, 0);
  endtask

  task automatic test_ignored_loads();
    logic [NW-1:0] exp_n [NIBBLES] = '{4'h0, 4'hF, 4'h0, 4'hF};
    tick(0, 1, 16'h0F0F, 0, 0);
    for (int i = 0; i < NIBBLES; i++) begin
      tick(0, 1, 16'hFFFF, 0, 0);
      total++;
      if (bus.out_nibble !== exp_n[i] || bus.nibble_index !== IW'(i)) begin
        bad++; $display("FAIL ign_show%0d got=%h exp=%h", i, bus.out_nibble, exp_n[i]);
      end
      tick(0, 1, 16'hFFFF, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 16'hFFFF, i[0], 0);
      total++;
      if (dut_vec() !== {4'h0, 1'b0, 2'd0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL ign_done%0d got=%h exp=%h", i, dut_vec(), {4'h0, 1'b0, 2'd0, 1'b1, 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(0, 0, '0, 0, 1);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL b2b_logout got=%h exp=0", dut_vec());
    end
    tick(0, 1, 16'h9876, 0, 0);
    total++;
    if (bus.out_nibble !== 4'h9 || bus.nibble_index !== 2'd0 || bus.nibble_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%h/%0d exp=9/0", bus.out_nibble, bus.nibble_index);
    end
    for (int i = 0; i < NIBBLES; i++) begin
      tick(0, 0, '0, 1, 0);
      tick(0, 0, '0, 0, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b_step%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++; $display("FAIL b2b_done got=%b exp=1", bus.done);
    end
    tick(0, 0, '0, 0, 1);
  endtask

  task automatic test_random();
    bit btn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, PW'($urandom),
           btn, $urandom_range(0, 24) == 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.in_pattern  = '0;
    bus.push_button = 1'b0;
    bus.logout      = 1'b0;
    test_reset();
    test_basic();
    test_held_button();
    test_priority();
    test_ignored_loads();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_unloader.md
Name: nibble_unloader

Overview:
- Inverse of the toggle-switch pattern capture stage.
- Accepts a completed 16-bit pattern (pattern + valid) and replays it one nibble at a time, most-significant nibble first, so the first nibble entered is the first shown.
- The operator steps through the nibbles with push_button. The block flags completion and waits for logout before accepting a new pattern.
- Sits between the pattern register and the LED/7-segment display path.

Parameters:
- NIBBLES, 4, number of nibbles per pattern. Pattern width PW = NIBBLES*NW.
- NW, 4, bits per nibble. Matches the toggle-switch width.
- IW, 2, width of nibble_index. Must satisfy 2**IW >= NIBBLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  pattern valid from the capture stage; sampled as a level.
- in_pattern  input  16 (PW)  pattern to replay; [15:12] is the first nibble.
- push_button  input  1  operator step button; level input, rising edge detected internally.
- logout  input  1  abort or finish request; returns the block to IDLE.
- out_nibble  output  4 (NW)  current nibble being presented.
- nibble_valid  output  1  out_nibble holds a live pattern nibble.
- nibble_index  output  2 (IW)  position of the current nibble; 0 = first/MSB.
- busy  output  1  high in SHOW and DONE. load is ignored while busy.
- done  output  1  all nibbles stepped through; held until logout.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE; internal pattern register=0; btn_prev=0.
  - All outputs 0: out_nibble=0, nibble_valid=0, nibble_index=0, busy=0, done=0.
  - Reset overrides every other input and aborts any replay in progress.
- Button edge detection:
  - btn_prev <= push_button every cycle in every state.
  - step = push_button & ~btn_prev.
  - A held button produces exactly one step.
  - A button already high when SHOW is entered does not step until it is released and pressed again.
- IDLE:
  - All outputs 0. push_button and logout have no effect.
  - load=1: latch in_pattern; next cycle go to SHOW with index=0, out_nibble=in_pattern[15:12], nibble_valid=1, busy=1.
  - Latency from load to first nibble is 1 cycle.
- SHOW:
  - out_nibble = pattern[PW-1-NW*index -: NW]; nibble_valid=1; busy=1.
  - step with index < NIBBLES-1: index increments; the new nibble appears on the next cycle.
  - step with index = NIBBLES-1: next cycle go to DONE.
  - logout=1: next cycle go to IDLE with all outputs cleared (abort). logout takes priority over a simultaneous step.
  - load is ignored; the latched pattern does not change.
- DONE:
  - done=1, busy=1, nibble_valid=0, out_nibble=0, nibble_index=0.
  - step and load are ignored.
  - logout=1: next cycle go to IDLE, done=0.
- Index never wraps within a replay. The final step always leads to DONE, never back to index 0.
- Outputs are registered. No combinational path from any input to any output.

Test Plan:
- Reset check: assert reset for 2 cycles mid-SHOW with pattern 16'hA5C3 at index 2 -> next cycle all outputs 0, state IDLE; later pulses on push_button produce nothing.
- Basic replay:
  - load=1 with in_pattern=16'hA5C3 -> next cycle out_nibble=4'hA, nibble_index=0, nibble_valid=1, busy=1.
  - Three 1-cycle presses -> 4'h5, 4'hC, 4'h3 at indices 1, 2, 3.
  - Fourth press -> done=1, nibble_valid=0.
  - logout -> all outputs 0 next cycle.
- Held button: hold push_button high for 10 cycles in SHOW with pattern 16'h1234 -> exactly one advance (4'h1 -> 4'h2). Button high at the load cycle causes no advance until released and re-pressed.
- Priority: in SHOW at index 1, assert logout and a push_button rising edge in the same cycle -> IDLE next cycle, done=0; no step taken.
- Ignored loads: load=1 with 16'hFFFF while in SHOW (pattern 16'h0F0F) and while in DONE -> displayed nibbles remain 4'h0/4'hF/4'h0/4'hF; done held until logout.
- Back-to-back patterns: after logout from DONE, load 16'h9876 on the first IDLE cycle -> next cycle out_nibble=4'h9, nibble_index=0; replay completes normally.
